// File: rtl/apb_modport.sv
// -----------------------------------------------------------------------------
// apb_modport
//   APB slave with a small byte-strobed register memory of MEM_DEPTH words.
//   Reads load prdata at the end of the setup phase, so read data is valid for
//   the whole access phase. Writes commit at the completing access edge.
//
//   Optional feature macro: APB_WAIT_STATE_EN
//     defined   -> every transfer takes exactly one wait state
//     undefined -> zero wait states (pready high in every access cycle)
//
// Ports
//   pclk     in   1           clock, rising edge
//   presetn  in   1           synchronous reset, ACTIVE-HIGH despite the name
//   paddr    in   ADDR_WIDTH  byte address
//   psel     in   1           slave select
//   penable  in   1           access phase indicator
//   pwrite   in   1           1 = write, 0 = read
//   pwdata   in   DATA_WIDTH  write data
//   pstrb    in   STRB_WIDTH  write byte enables
//   prdata   out  DATA_WIDTH  registered read data
//   pready   out  1           transfer completion (combinational)
//   pslverr  out  1           error response for a bad address
// -----------------------------------------------------------------------------
module apb_modport #(
  parameter  int ADDR_WIDTH = 8,
  parameter  int DATA_WIDTH = 32,
  parameter  int MEM_DEPTH  = 16,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  // Number of byte-offset bits inside one word (0 for an 8-bit bus).
  localparam int OFF_BITS = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  // Storage index width; kept at least 1 so a single-word memory still elaborates.
  localparam int IDX_BITS = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  // An address is bad when it is past the last word or not word aligned.
  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] idx;
    idx = a >> OFF_BITS;
    return (32'(idx) >= 32'(MEM_DEPTH)) || ((a & OFF_MASK) != {ADDR_WIDTH{1'b0}});
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [IDX_BITS-1:0]   mem_idx_s;
  logic                  addr_err_s;
  logic                  setup_s;
  logic                  access_s;
  logic                  rd_setup_s;
  logic                  pready_s;
  logic                  wr_en_s;

`ifdef APB_WAIT_STATE_EN
  logic                  wait_r;

  // Wait-state flag: set in the first access cycle, cleared once the transfer completes.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      wait_r <= 1'b0;
    end else begin
      wait_r <= access_s & ~wait_r;
    end
  end
`endif

  // Phase decode, address check and handshake outputs.
  always_comb begin
    word_idx_s = paddr >> OFF_BITS;
    mem_idx_s  = word_idx_s[IDX_BITS-1:0];
    addr_err_s = addr_bad(paddr);
    setup_s    = psel & ~penable;
    access_s   = psel & penable;
    rd_setup_s = setup_s & ~pwrite;
`ifdef APB_WAIT_STATE_EN
    // First access cycle waits; pready rises once wait_r has been set.
    pready_s   = access_s & wait_r & ~presetn;
`else
    pready_s   = access_s & ~presetn;
`endif
    // Reset has priority in the storage process, so gating here is for the bus only.
    wr_en_s    = pready_s & pwrite & ~addr_err_s;
    pready     = pready_s;
    pslverr    = pready_s & addr_err_s;
  end

  // Storage writes with byte strobes and registered read data capture.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      prdata <= {DATA_WIDTH{1'b0}};
    end else begin
      if (wr_en_s) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (pstrb[b]) begin
            mem_r[mem_idx_s][8*b +: 8] <= pwdata[8*b +: 8];
          end
        end
      end
      // Loaded at the end of a read setup phase and held through wait states.
      if (rd_setup_s) begin
        prdata <= addr_err_s ? {DATA_WIDTH{1'b0}} : mem_r[mem_idx_s];
      end
    end
  end

endmodule

// File: tb/tb_apb_modport.sv
// -----------------------------------------------------------------------------
// tb_apb_modport
//   Directed bench for apb_modport (default parameters). Expected values are
//   hand-computed constants. Works with or without APB_WAIT_STATE_EN; the
//   expected wait-state count per transfer follows the macro.
// -----------------------------------------------------------------------------
module tb_apb_modport;

`ifdef APB_WAIT_STATE_EN
  localparam int EXP_WAITS = 1;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic        pclk;
  logic        presetn;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int vecs = 0;
  int errs = 0;

  logic [31:0] rd;
  logic        err;
  int          w;

  apb_modport dut (
    .pclk    (pclk),
    .presetn (presetn),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer; returns at the negedge of the completing access cycle.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rdo,
                      output logic erro, output int wo);
    wo = 0;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    while (pready !== 1'b1 && wo < 8) begin
      wo++;
      @(negedge pclk);
      #1;
    end
    chk("pready_timeout", {31'd0, pready}, 32'd1);
    rdo  = prdata;
    erro = pslverr;
  endtask

  task automatic idle();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1;
  endtask

  initial begin
    presetn = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 32'h0; pstrb = 4'h0;
    repeat (2) @(negedge pclk);
    #1;
    chk("reset_prdata", prdata, 32'h0);
    chk("reset_pready", {31'd0, pready}, 32'd0);
    @(negedge pclk);
    presetn = 1'b0;

    // Read after reset
    xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, err, w);
    chk("rd04_data", rd, 32'h0000_0000);
    chk("rd04_err", {31'd0, err}, 32'd0);
    chk("rd04_waits", 32'(w), 32'(EXP_WAITS));

    // Full word write then read
    xfer(1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, rd, err, w);
    chk("wr08_err", {31'd0, err}, 32'd0);
    xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, err, w);
    chk("rd08_data", rd, 32'hDEAD_BEEF);
    chk("rd08_err", {31'd0, err}, 32'd0);

    // Partial strobes 0101
    xfer(1'b1, 8'h08, 32'h1122_3344, 4'h5, rd, err, w);
    xfer(1'b0, 8'h08, 32'h0, 4'hF, rd, err, w);
    chk("rd08_strb5", rd, 32'hDE22_BE44);

    // Out-of-range write / read
    xfer(1'b1, 8'h40, 32'hCAFE_F00D, 4'hF, rd, err, w);
    chk("wr40_err", {31'd0, err}, 32'd1);
    xfer(1'b0, 8'h40, 32'h0, 4'h0, rd, err, w);
    chk("rd40_data", rd, 32'h0);
    chk("rd40_err", {31'd0, err}, 32'd1);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, err, w);
    chk("rd00_noalias", rd, 32'h0);
    xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, err, w);
    chk("rd08_after40", rd, 32'hDE22_BE44);

    // Misaligned read
    xfer(1'b0, 8'h02, 32'h0, 4'h0, rd, err, w);
    chk("rd02_err", {31'd0, err}, 32'd1);
    chk("rd02_data", rd, 32'h0);

    // Zero-strobe write changes nothing
    xfer(1'b1, 8'h04, 32'hFFFF_FFFF, 4'h0, rd, err, w);
    chk("wr04_strb0_err", {31'd0, err}, 32'd0);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, err, w);
    chk("rd04_strb0", rd, 32'h0);

    // Back-to-back write then read of the same word, no idle
    xfer(1'b1, 8'h14, 32'h1357_9BDF, 4'hF, rd, err, w);
    xfer(1'b0, 8'h14, 32'h0, 4'h0, rd, err, w);
    chk("b2b_rd14", rd, 32'h1357_9BDF);
    idle();
    chk("prdata_held", prdata, 32'h1357_9BDF);

    // Wait-state behaviour on word 0x10
    xfer(1'b1, 8'h10, 32'h0BAD_C0DE, 4'hF, rd, err, w);
    chk("wr10_waits", 32'(w), 32'(EXP_WAITS));
    xfer(1'b0, 8'h10, 32'h0, 4'h0, rd, err, w);
    chk("rd10_waits", 32'(w), 32'(EXP_WAITS));
    chk("rd10_data", rd, 32'h0BAD_C0DE);
    idle();

    // penable without psel is ignored
    @(negedge pclk);
    psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 8'h18;
    pwdata = 32'h7777_7777; pstrb = 4'hF;
    #1;
    chk("nosel_pready", {31'd0, pready}, 32'd0);
    idle();
    xfer(1'b0, 8'h18, 32'h0, 4'h0, rd, err, w);
    chk("rd18_nosel", rd, 32'h0);
    idle();

    // Reset asserted during the access phase of a write
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C;
    pwdata = 32'hA5A5_A5A5; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1; presetn = 1'b1;
    #1;
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    @(negedge pclk);
    presetn = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, w);
    chk("rd0c_after_rst", rd, 32'h0);
    xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, err, w);
    chk("rd08_after_rst", rd, 32'h0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
